// File: rtl/gpio_wiggle_gen_pkg.sv
// Shared types and constants for the GPIO wiggle pattern generator.
package gpio_wiggle_pkg;

  localparam int unsigned MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    MODE_TOGGLE = 2'd0,
    MODE_WALK   = 2'd1,
    MODE_COUNT  = 2'd2,
    MODE_LFSR   = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    CFG_IDLE    = 2'd0,
    CFG_PEND    = 2'd1,
    CFG_APPLIED = 2'd2
  } cfg_state_e;

  // Galois right-shift feedback masks for common widths
  localparam logic [15:0] LFSR_TAPS_16 = 16'hB400;
  localparam logic [31:0] LFSR_TAPS_32 = 32'h8020_0003;
  localparam logic [63:0] LFSR_TAPS_64 = 64'hD800_0000_0000_0000;

endpackage

// File: rtl/gpio_wiggle_gen_if.sv
// Configuration valid/ready channel for gpio_wiggle_gen.
interface gpio_wiggle_gen_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DIV_W = 24
);
  logic             cfg_valid;
  logic             cfg_ready;
  logic [1:0]       cfg_mode;
  logic [DIV_W-1:0] cfg_div;
  logic [WIDTH-1:0] cfg_seed;

  modport master (output cfg_valid, cfg_mode, cfg_div, cfg_seed, input cfg_ready);
  modport slave  (input cfg_valid, cfg_mode, cfg_div, cfg_seed, output cfg_ready);
endinterface

// File: rtl/gpio_wiggle_gen_prescaler.sv
// Step prescaler: counts 0..div while enabled, pulses step on wrap; divider reloads only on load.
module wiggle_prescaler #(
  parameter int unsigned      DIV_W       = 24,
  parameter logic [DIV_W-1:0] DIV_DEFAULT = DIV_W'(49)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             load,
  input  logic [DIV_W-1:0] load_div,
  output logic             wrap_c,
  output logic             step
);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             step_q, step_d;

  assign wrap_c = en && (cnt_q == div_q);
  assign step   = step_q;

  // A load restarts the period from zero with the new divider
  always_comb begin
    cnt_d  = cnt_q;
    div_d  = div_q;
    step_d = wrap_c;
    if (load) begin
      cnt_d = '0;
      div_d = load_div;
    end else if (wrap_c) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + DIV_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      div_q  <= DIV_DEFAULT;
      step_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      div_q  <= div_d;
      step_q <= step_d;
    end
  end

endmodule

// File: rtl/gpio_wiggle_gen.sv
// GPIO pattern generator (toggle/walk/count/LFSR) with shadowed config applied at step boundaries.
// Optional GPIO_WIGGLE_MASK_EN adds a gpio_mask input that blanks pins on the output only.
module gpio_wiggle_gen
  import gpio_wiggle_pkg::*;
#(
  parameter int unsigned      WIDTH       = 32,
  parameter int unsigned      DIV_W       = 24,
  parameter logic [DIV_W-1:0] DIV_DEFAULT = DIV_W'(49),
  parameter logic [63:0]      LFSR_TAPS   = 64'(LFSR_TAPS_32)
) (
  input  logic               osc,
  input  logic               perstn,
  input  logic               en,
  gpio_wiggle_gen_if.slave   cfg,
`ifdef GPIO_WIGGLE_MASK_EN
  input  logic [WIDTH-1:0]   gpio_mask,
`endif
  output logic [WIDTH-1:0]   gpio_out,
  output logic               step,
  output logic [31:0]        step_cnt
);

  localparam logic [WIDTH-1:0] TAPS = LFSR_TAPS[WIDTH-1:0];

  cfg_state_e       state_q, state_d;
  logic             cfg_ready_q, cfg_ready_d;
  mode_e            sh_mode_q, sh_mode_d;
  logic [DIV_W-1:0] sh_div_q, sh_div_d;
  logic [WIDTH-1:0] sh_seed_q, sh_seed_d;
  mode_e            mode_q, mode_d;
  logic [WIDTH-1:0] pattern_q, pattern_d;
  logic [31:0]      step_cnt_q, step_cnt_d;
  logic             wrap_c;
  logic             apply_c;

  function automatic logic [WIDTH-1:0] advance(mode_e m, logic [WIDTH-1:0] p);
    logic [WIDTH-1:0] n;
    case (m)
      MODE_TOGGLE: n = ~p;
      MODE_WALK:   n = (p == '0) ? WIDTH'(1) : {p[WIDTH-2:0], p[WIDTH-1]};
      MODE_COUNT:  n = p + WIDTH'(1);
      default: begin
        n = (p >> 1) ^ (p[0] ? TAPS : '0);
        if (n == '0) n = WIDTH'(1);
      end
    endcase
    return n;
  endfunction

  // Walk and LFSR cannot leave the all-zero state, so a zero seed starts them at 1
  function automatic logic [WIDTH-1:0] seed_fix(mode_e m, logic [WIDTH-1:0] s);
    if (((m == MODE_WALK) || (m == MODE_LFSR)) && (s == '0)) return WIDTH'(1);
    return s;
  endfunction

  wiggle_prescaler #(
    .DIV_W       (DIV_W),
    .DIV_DEFAULT (DIV_DEFAULT)
  ) u_prescaler (
    .clk      (osc),
    .rst_n    (perstn),
    .en       (en),
    .load     (apply_c),
    .load_div (sh_div_q),
    .wrap_c   (wrap_c),
    .step     (step)
  );

  // Config handshake: capture into shadow, hold off until applied, re-open one cycle later
  always_comb begin
    state_d     = state_q;
    cfg_ready_d = cfg_ready_q;
    sh_mode_d   = sh_mode_q;
    sh_div_d    = sh_div_q;
    sh_seed_d   = sh_seed_q;
    apply_c     = 1'b0;
    case (state_q)
      CFG_IDLE: begin
        if (cfg.cfg_valid) begin
          state_d   = CFG_PEND;
          sh_mode_d = mode_e'(cfg.cfg_mode);
          sh_div_d  = cfg.cfg_div;
          sh_seed_d = cfg.cfg_seed;
        end
      end
      CFG_PEND: begin
        if (!en || wrap_c) begin
          state_d = CFG_APPLIED;
          apply_c = 1'b1;
        end
      end
      CFG_APPLIED: state_d = CFG_IDLE;
      default:     state_d = CFG_IDLE;
    endcase
    cfg_ready_d = (state_d == CFG_IDLE);
  end

  // An apply replaces the advance on its step edge
  always_comb begin
    mode_d     = mode_q;
    pattern_d  = pattern_q;
    step_cnt_d = step_cnt_q;
    if (apply_c) begin
      mode_d    = sh_mode_q;
      pattern_d = seed_fix(sh_mode_q, sh_seed_q);
    end else if (wrap_c) begin
      pattern_d = advance(mode_q, pattern_q);
    end
    if (wrap_c) step_cnt_d = step_cnt_q + 32'd1;
  end

  always_ff @(posedge osc) begin
    if (!perstn) begin
      state_q     <= CFG_IDLE;
      cfg_ready_q <= 1'b1;
      sh_mode_q   <= MODE_TOGGLE;
      sh_div_q    <= DIV_DEFAULT;
      sh_seed_q   <= '0;
      mode_q      <= MODE_TOGGLE;
      pattern_q   <= '0;
      step_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      cfg_ready_q <= cfg_ready_d;
      sh_mode_q   <= sh_mode_d;
      sh_div_q    <= sh_div_d;
      sh_seed_q   <= sh_seed_d;
      mode_q      <= mode_d;
      pattern_q   <= pattern_d;
      step_cnt_q  <= step_cnt_d;
    end
  end

  assign cfg.cfg_ready = cfg_ready_q;
  assign step_cnt      = step_cnt_q;

`ifdef GPIO_WIGGLE_MASK_EN
  assign gpio_out = pattern_q & ~gpio_mask;
`else
  assign gpio_out = pattern_q;
`endif

endmodule

// File: tb/tb_gpio_wiggle_gen.sv
// Self-checking bench for gpio_wiggle_gen: directed test-plan steps plus randomized configs vs. a step-level model.
module tb_gpio_wiggle_gen;

  localparam logic [31:0] TAPS = 32'h8020_0003;

  logic        osc;
  logic        perstn;
  logic        en;
  logic [31:0] gpio_out;
  logic        step;
  logic [31:0] step_cnt;
  logic [31:0] mask_v;

  gpio_wiggle_gen_if #(.WIDTH(32), .DIV_W(24)) cfg_if ();

`ifdef GPIO_WIGGLE_MASK_EN
  logic [31:0] gpio_mask;
  assign gpio_mask = mask_v;
`endif

  gpio_wiggle_gen #(.WIDTH(32), .DIV_W(24)) dut (
    .osc      (osc),
    .perstn   (perstn),
    .en       (en),
    .cfg      (cfg_if),
`ifdef GPIO_WIGGLE_MASK_EN
    .gpio_mask(gpio_mask),
`endif
    .gpio_out (gpio_out),
    .step     (step),
    .step_cnt (step_cnt)
  );

  initial osc = 1'b0;
  always #5 osc = ~osc;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  // Reference model: pattern, active config, enabled edges left in the current period
  logic [31:0] m_pat = '0;
  int          m_mode = 0;
  longint      m_div = 49;
  longint      m_left = 50;
  bit          m_step = 0;
  logic [31:0] m_scnt = '0;
  bit          m_ready = 1;
  bit          m_pend = 0;
  bit          m_app_prev = 0;
  int          sh_mode = 0;
  longint      sh_div = 49;
  logic [31:0] sh_seed = '0;

  function automatic logic [31:0] adv(int md, logic [31:0] p);
    logic [31:0] n;
    case (md)
      0: n = ~p;
      1: n = (p == 0) ? 32'd1 : ((p << 1) | (p >> 31));
      2: n = p + 32'd1;
      default: begin
        n = (p >> 1) ^ (p[0] ? TAPS : 32'd0);
        if (n == 0) n = 32'd1;
      end
    endcase
    return n;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
  endtask

  task automatic model_edge(output bit hs);
    bit stp, app;
    hs = 0;
    if (!perstn) begin
      m_pat = 0; m_mode = 0; m_div = 49; m_left = 50; m_step = 0; m_scnt = 0;
      m_ready = 1; m_pend = 0; m_app_prev = 0;
      return;
    end
    stp = en && (m_left == 1);
    app = m_pend && (!en || stp);
    hs  = cfg_if.cfg_valid && m_ready;
    if (m_app_prev) m_ready = 1;
    m_step = stp;
    if (stp) m_scnt = m_scnt + 1;
    if (app) begin
      m_mode = sh_mode;
      m_div  = sh_div;
      m_pat  = ((sh_mode == 1 || sh_mode == 3) && sh_seed == 0) ? 32'd1 : sh_seed;
      m_left = sh_div + 1;
      m_pend = 0;
    end else if (stp) begin
      m_pat  = adv(m_mode, m_pat);
      m_left = m_div + 1;
    end else if (en) begin
      m_left = m_left - 1;
    end
    m_app_prev = app;
    if (hs) begin
      m_pend  = 1;
      m_ready = 0;
      sh_mode = int'(cfg_if.cfg_mode);
      sh_div  = longint'(cfg_if.cfg_div);
      sh_seed = cfg_if.cfg_seed;
    end
  endtask

  task automatic tick(output bit hs);
    model_edge(hs);
    @(posedge osc);
    #1;
    cyc++;
    chk("gpio_out", 64'(gpio_out), 64'(m_pat & ~mask_v));
    chk("step", 64'(step), 64'(m_step));
    chk("step_cnt", 64'(step_cnt), 64'(m_scnt));
    chk("cfg_ready", 64'(cfg_if.cfg_ready), 64'(m_ready));
  endtask

  task automatic run(input int n);
    bit hs;
    for (int i = 0; i < n; i++) tick(hs);
  endtask

  task automatic offer(input logic [1:0] md, input logic [23:0] dv, input logic [31:0] sd);
    bit hs;
    int n;
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_mode  = md;
    cfg_if.cfg_div   = dv;
    cfg_if.cfg_seed  = sd;
    hs = 0;
    n  = 0;
    while (!hs && n < 300) begin
      tick(hs);
      n++;
    end
    cfg_if.cfg_valid = 1'b0;
    chk("offer_accepted", 64'(hs), 64'd1);
  endtask

  task automatic wait_step();
    bit hs;
    int n;
    n = 0;
    do begin
      tick(hs);
      n++;
    end while (step !== 1'b1 && n < 300);
    chk("step_seen", 64'(step), 64'd1);
  endtask

  initial begin
    perstn = 1'b0;
    en     = 1'b0;
    mask_v = '0;
    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_mode  = '0;
    cfg_if.cfg_div   = '0;
    cfg_if.cfg_seed  = '0;

    // Reset state
    run(2);
    chk("rst_gpio", 64'(gpio_out), 64'd0);
    chk("rst_ready", 64'(cfg_if.cfg_ready), 64'd1);
    chk("rst_scnt", 64'(step_cnt), 64'd0);

    // Default toggle, step every 50 cycles
    perstn = 1'b1;
    en     = 1'b1;
    run(49);
    chk("dflt_no_step_49", 64'(step), 64'd0);
    run(1);
    chk("dflt_step_50", 64'(step), 64'd1);
    chk("dflt_gpio_1", 64'(gpio_out), 64'hFFFF_FFFF);
    run(200);
    chk("dflt_scnt_5", 64'(step_cnt), 64'd5);
    chk("dflt_gpio_5", 64'(gpio_out), 64'hFFFF_FFFF);

    // WALK div=0 seed=0, applied at next step
    offer(2'd1, 24'd0, 32'd0);
    chk("walk_ready_low", 64'(cfg_if.cfg_ready), 64'd0);
    wait_step();
    chk("walk_load", 64'(gpio_out), 64'd1);
    run(1);
    chk("walk_2", 64'(gpio_out), 64'd2);
    chk("walk_ready_back", 64'(cfg_if.cfg_ready), 64'd1);
    run(30);
    chk("walk_msb", 64'(gpio_out), 64'h8000_0000);
    run(1);
    chk("walk_wrap", 64'(gpio_out), 64'd1);

    // COUNT div=3 across the wrap
    offer(2'd2, 24'd3, 32'hFFFF_FFFE);
    wait_step();
    chk("cnt_load", 64'(gpio_out), 64'hFFFF_FFFE);
    run(3);
    chk("cnt_no_step", 64'(step), 64'd0);
    run(1);
    chk("cnt_step4", 64'(step), 64'd1);
    chk("cnt_ffff", 64'(gpio_out), 64'hFFFF_FFFF);
    run(4);
    chk("cnt_wrap0", 64'(gpio_out), 64'd0);

    // LFSR zero seed, then a long run the model keeps honest
    offer(2'd3, 24'd0, 32'd0);
    wait_step();
    chk("lfsr_load", 64'(gpio_out), 64'd1);
    run(1);
    chk("lfsr_first", 64'(gpio_out), 64'h8020_0003);
    for (int i = 0; i < 1000; i++) begin
      bit hs;
      tick(hs);
      if (gpio_out == 32'd0) chk("lfsr_nonzero", 64'(gpio_out), 64'd1);
    end
    chk("lfsr_nonzero_end", 64'(gpio_out == 32'd0), 64'd0);

    // en=0: apply next cycle, no step, ready back two cycles after handshake
    en = 1'b0;
    run(3);
    offer(2'd2, 24'd7, 32'h1234_5678);
    chk("en0_ready_low", 64'(cfg_if.cfg_ready), 64'd0);
    run(1);
    chk("en0_applied", 64'(gpio_out), 64'h1234_5678);
    chk("en0_no_step", 64'(step), 64'd0);
    run(1);
    chk("en0_ready_back", 64'(cfg_if.cfg_ready), 64'd1);
    en = 1'b1;
    run(8);
    chk("en0_new_div", 64'(gpio_out), 64'h1234_5679);

    // Reset while a config is pending
    perstn = 1'b0;
    run(1);
    perstn = 1'b1;
    offer(2'd1, 24'd2, 32'hAAAA_0000);
    run(5);
    perstn = 1'b0;
    run(1);
    chk("rstp_ready", 64'(cfg_if.cfg_ready), 64'd1);
    chk("rstp_gpio", 64'(gpio_out), 64'd0);
    chk("rstp_scnt", 64'(step_cnt), 64'd0);
    perstn = 1'b1;
    run(50);
    chk("rstp_default_toggle", 64'(gpio_out), 64'hFFFF_FFFF);

`ifdef GPIO_WIGGLE_MASK_EN
    // Output mask blanks low half; pattern keeps toggling underneath
    mask_v = 32'h0000_FFFF;
    offer(2'd0, 24'd0, 32'd0);
    wait_step();
    chk("mask_load", 64'(gpio_out), 64'd0);
    run(1);
    chk("mask_hi", 64'(gpio_out), 64'hFFFF_0000);
    run(1);
    chk("mask_lo", 64'(gpio_out), 64'd0);
`endif

    // Randomized configs with en toggling and junk on the config bus between offers
    for (int k = 0; k < 25; k++) begin
      en = ($urandom_range(0, 3) != 0);
`ifdef GPIO_WIGGLE_MASK_EN
      mask_v = $urandom;
`endif
      offer(2'($urandom_range(0, 3)), 24'($urandom_range(0, 5)),
            ($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom));
      for (int j = 0, nj = $urandom_range(0, 30); j < nj; j++) begin
        bit hs;
        en = ($urandom_range(0, 4) != 0);
        cfg_if.cfg_mode = 2'($urandom);
        cfg_if.cfg_div  = 24'($urandom);
        cfg_if.cfg_seed = 32'($urandom);
        tick(hs);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/gpio_wiggle_gen.md
Name: gpio_wiggle_gen

Overview:
Parametrised GPIO pattern generator; successor to the fixed toggle logic driving gpio_a/gpio_b in the wiggle top level. Drives WIDTH pins from one of four patterns (toggle, walking-one, binary count, LFSR), advanced by a programmable prescaler. Configuration uses a valid/ready handshake and is applied glitch-free at a step boundary. One instance per GPIO bank, clocked from osc.

Parameters:
WIDTH, 32, number of GPIO outputs (2..64)
DIV_W, 24, prescaler divide-value width
DIV_DEFAULT, 24'd49, divide value after reset (step every DIV_DEFAULT+1 cycles)
LFSR_TAPS, 32'h8020_0003, Galois feedback mask (bit i set = tap); low WIDTH bits used

Ports:
osc  input  1  clock
perstn  input  1  synchronous active-low reset
en  input  1  run enable; 0 freezes prescaler and pattern
cfg_valid  input  1  config offer
cfg_ready  output  1  config accepted when valid&ready
cfg_mode  input  2  0 TOGGLE, 1 WALK, 2 COUNT, 3 LFSR
cfg_div  input  DIV_W  step period minus one
cfg_seed  input  WIDTH  initial pattern
gpio_out  output  WIDTH  pattern to pads
step  output  1  one-cycle pulse on each pattern advance
step_cnt  output  32  steps since reset, wraps 2^32-1 -> 0

Behaviour:
- Reset is synchronous and active-low: on a rising osc edge with perstn=0: gpio_out=0, step=0, step_cnt=0, prescaler=0, mode=TOGGLE, div=DIV_DEFAULT, cfg_ready=1, no pending config.
- Prescaler: en=1 -> counts 0..div; at div, wraps to 0 and asserts step for that cycle. div=0 -> step every cycle. en=0 -> counter holds, step=0.
- On step, gpio_out updates registered (visible the cycle after step goes high... no: same edge; step and new gpio_out appear together, latency 0 from step).
- TOGGLE: gpio_out <= ~gpio_out.
- WALK: rotate left by 1; MSB wraps to bit 0. All-zero pattern reloads 1.
- COUNT: gpio_out <= gpio_out + 1, mod 2^WIDTH.
- LFSR: Galois, shift right; if old LSB=1, XOR LFSR_TAPS. All-zero state replaced by 1.
- step_cnt increments on every step.
- Config handshake: transfer when cfg_valid & cfg_ready; mode/div/seed captured into shadow; cfg_ready drops next cycle until applied.
- Apply: en=0 -> next cycle; en=1 -> at next step edge (instead of advancing). Apply loads mode, div, gpio_out=cfg_seed (WALK/LFSR zero seed -> 1), prescaler=0; step still pulses, step_cnt increments. cfg_ready returns 1 the cycle after apply.
- cfg_valid with cfg_ready=0 ignored; master holds until ready.
- Shadow changed from apply-edge to idle: new div takes effect from prescaler=0, no short/long period.
- Reset mid-pending: shadow discarded, defaults restored.
- cfg_div change while running never truncates current period (div register only written at apply).

Optional Feature:
GPIO_WIGGLE_MASK_EN: adds input gpio_mask[WIDTH]; gpio_out = pattern & ~gpio_mask, combinational mask on registered pattern, internal pattern advances regardless. Without macro: no port, gpio_out = pattern.

Decomposition:
- Package gpio_wiggle_pkg: mode constants MODE_TOGGLE/WALK/COUNT/LFSR, mode width 2, default LFSR taps for 16/32/64.
- Sub-module wiggle_prescaler (counter, div register load, step pulse); pattern logic and handshake in top.

Test Plan:
- Reset with defaults, en=1, 250 cycles -> step every 50 cycles, gpio_out 0 -> FFFF_FFFF -> 0, step_cnt=5.
- Config WALK div=0 seed=0 with en=1 -> cfg_ready low until next step; then gpio_out 1,2,4..8000_0000,1 each cycle; wrap after 32 steps.
- COUNT div=3 seed=FFFF_FFFE -> FFFF_FFFF then 0 four cycles later; step period exactly 4.
- LFSR seed=0 -> loaded as 1; next step 8020_0003 (tap XOR after shift); no all-zero state over 1000 steps.
- en=0 then config offer -> applied next cycle, cfg_ready back 1 two cycles after handshake, no step; perstn=0 while pending -> defaults, cfg_ready=1.
- With GPIO_WIGGLE_MASK_EN, TOGGLE, mask=0000_FFFF -> gpio_out alternates FFFF_0000 / 0000_0000.
